ultrasonic_scan_scheduler: RTL and testbench
============================================

ULTRASONIC_SCAN_SCHEDULER -- requirements
Module: ultrasonic_scan_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, 4, number of sensor channels sharing one measurement engine (2..8).
REQ-002 Parameter CLK_PER_US, 50, clk cycles per microsecond tick.
REQ-003 Parameter TRIG_US, 10, trigger pulse width in us.
REQ-004 Parameter RISE_TIMEOUT_US, 2000, max us from trigger end to echo rise.
REQ-005 Parameter MAX_ECHO_US, 30000, echo width limit in us.
REQ-006 Parameter HOLDOFF_US, 10000, quiet time between measurements in us.
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  scanning permitted when high.
REQ-010 sensor_mask  in  NUM_SENSORS  per-channel scan enable.
REQ-011 echo  in  NUM_SENSORS  asynchronous sensor echo lines.
REQ-012 trigger  out  NUM_SENSORS  registered trigger pulses, at most one high.
REQ-013 result_data  out  16  echo width in us, saturating.
REQ-014 result_id  out  clog2(NUM_SENSORS)  channel of current result.
REQ-015 result_timeout  out  1  result is a timeout/overrange.
REQ-016 result_valid  out  1  result available; held until accepted.
REQ-017 result_ready  in  1  consumer accepts result when high with result_valid.
REQ-018 busy  out  1  high in any state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, SELECT, TRIGGER, WAIT_RISE, MEASURE, REPORT, HOLDOFF.
REQ-020 IDLE -> SELECT when enable=1 and sensor_mask!=0; otherwise remain IDLE.
REQ-021 SELECT SHALL pick the next masked channel after the last served one (round-robin, wrapping NUM_SENSORS-1 -> 0), one cycle, then -> TRIGGER; mask and enable sampled only here; if enable=0 or mask=0 -> IDLE.
REQ-022 TRIGGER: trigger[sel] high for exactly TRIG_US*CLK_PER_US cycles, starting the cycle after SELECT, then -> WAIT_RISE.
REQ-023 echo SHALL pass a 2-flop synchronizer plus edge detector; rise/fall seen 3 cycles after the pin changes.
REQ-024 WAIT_RISE: synchronized rising edge on echo[sel] -> MEASURE; echo already high without edge SHALL NOT start measurement; RISE_TIMEOUT_US elapsed -> REPORT with result_timeout=1, result_data=16'hFFFF.
REQ-025 MEASURE: us prescaler cleared on entry; width counter +1 per completed us; falling edge -> REPORT with counter value, result_timeout=0.
REQ-026 MEASURE: counter reaching MAX_ECHO_US -> REPORT with result_timeout=1, result_data=16'hFFFF; counter never wraps.
REQ-027 REPORT: result_valid=1, result_data/id/timeout stable; leave to HOLDOFF on the cycle result_valid&&result_ready; otherwise wait indefinitely.
REQ-028 HOLDOFF: wait HOLDOFF_US, then -> SELECT.
REQ-029 enable or mask changes outside SELECT/IDLE SHALL NOT abort the measurement in progress.
REQ-030 Echo on non-selected channels SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE, trigger=0, result_valid=0, result_data=0, result_id=0, result_timeout=0, busy=0, all counters and synchronizers 0, last-served pointer = NUM_SENSORS-1 (so channel 0 is served first).
REQ-032 Reset asserted mid-operation SHALL drop trigger and result_valid on the next edge, discarding any pending result.

Structure
REQ-033 Package ultrasonic_pkg SHALL hold the state enum and default timing constants.
REQ-034 Sub-module echo_sync (2-flop synchronizer + rise/fall detector, one per channel) SHALL be instantiated NUM_SENSORS times.

Verification (CLK_PER_US=2, TRIG_US=2, RISE_TIMEOUT_US=20, MAX_ECHO_US=50, HOLDOFF_US=5)
REQ-035 mask=4'b0101, echo responses 30 us wide -> results id 0,2,0,2..., result_data=30 each, timeout=0, trigger exactly 4 cycles.
REQ-036 mask=4'b0001, echo never rises -> result_timeout=1, result_data=16'hFFFF, 40 cycles after trigger ends (+sync slack).
REQ-037 echo held high 60 us -> result_data=16'hFFFF, timeout=1 at 50 us.
REQ-038 result_ready=0 for 100 cycles in REPORT -> result_valid and data stable, no new trigger until accept.
REQ-039 mask cleared and enable dropped during MEASURE -> current result delivered, then IDLE, busy=0.
REQ-040 reset asserted during TRIGGER -> next cycle trigger=0, result_valid=0; after release, channel 0 served first.

Source files
------------

// File: rtl/ultrasonic_scan_scheduler_pkg.sv
// Shared types and default timing for the ultrasonic scan scheduler:
// the scheduler state encoding and the production timing defaults.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        TRIGGER,
        WAIT_RISE,
        MEASURE,
        REPORT,
        HOLDOFF
    } state_t;

    localparam int DEF_NUM_SENSORS     = 4;
    localparam int DEF_CLK_PER_US      = 50;
    localparam int DEF_TRIG_US         = 10;
    localparam int DEF_RISE_TIMEOUT_US = 2000;
    localparam int DEF_MAX_ECHO_US     = 30000;
    localparam int DEF_HOLDOFF_US      = 10000;

    localparam int          RESULT_W   = 16;
    localparam logic [15:0] RESULT_SAT = 16'hFFFF;

endpackage

// File: rtl/ultrasonic_scan_scheduler_if.sv
// Result handshake between the scan scheduler (master) and its consumer (slave).
interface ultrasonic_scan_scheduler_if #(
    parameter int ID_W = 2
);
    import ultrasonic_pkg::*;

    logic [RESULT_W-1:0] result_data;
    logic [ID_W-1:0]     result_id;
    logic                result_timeout;
    logic                result_valid;
    logic                result_ready;

    modport master (
        output result_data, result_id, result_timeout, result_valid,
        input  result_ready
    );

    modport slave (
        input  result_data, result_id, result_timeout, result_valid,
        output result_ready
    );

endinterface

// File: rtl/ultrasonic_scan_scheduler_echo_sync.sv
// Two-flop synchronizer for one asynchronous echo line, plus a third stage
// used to detect synchronized rising and falling edges.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo_in,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], echo_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler that shares one echo-width measurement engine across
// several ultrasonic sensors and reports each result through a valid/ready handshake.
module ultrasonic_scan_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int NUM_SENSORS     = DEF_NUM_SENSORS,
    parameter int CLK_PER_US      = DEF_CLK_PER_US,
    parameter int TRIG_US         = DEF_TRIG_US,
    parameter int RISE_TIMEOUT_US = DEF_RISE_TIMEOUT_US,
    parameter int MAX_ECHO_US     = DEF_MAX_ECHO_US,
    parameter int HOLDOFF_US      = DEF_HOLDOFF_US
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   busy,
    ultrasonic_scan_scheduler_if.master res
);

    localparam int ID_W = $clog2(NUM_SENSORS);
    localparam int PW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    localparam logic [PW-1:0]          PRESC_LAST = PW'(CLK_PER_US - 1);
    localparam logic [15:0]            TRIG_LAST  = 16'(TRIG_US - 1);
    localparam logic [15:0]            RISE_LAST  = 16'(RISE_TIMEOUT_US - 1);
    localparam logic [15:0]            ECHO_LAST  = 16'(MAX_ECHO_US - 1);
    localparam logic [15:0]            HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [ID_W-1:0]        LAST_CH    = ID_W'(NUM_SENSORS - 1);
    localparam logic [NUM_SENSORS-1:0] ONE_HOT0   = NUM_SENSORS'(1);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        sel_q, sel_d, last_q;
    logic [ID_W-1:0]        cand, next_ch;
    logic                   next_found;
    logic [PW-1:0]          presc_q;
    logic [15:0]            us_q;
    logic                   tick;
    logic [15:0]            data_q, data_d;
    logic                   tmo_q, tmo_d;
    logic                   valid_q;
    logic [NUM_SENSORS-1:0] trig_q;
    logic [NUM_SENSORS-1:0] echo_rise, echo_fall;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sync
        echo_sync u_sync (
            .clk     (clk),
            .reset   (reset),
            .echo_in (echo[g]),
            .rise    (echo_rise[g]),
            .fall    (echo_fall[g])
        );
    end

    assign tick = (presc_q == PRESC_LAST);

    // First masked channel strictly after the last served one, wrapping.
    always_comb begin
        cand       = last_q;
        next_ch    = last_q;
        next_found = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
            if (!next_found && sensor_mask[cand]) begin
                next_ch    = cand;
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (enable && next_found) state_d = SELECT;
            end
            SELECT: begin
                if (enable && next_found) begin
                    state_d = TRIGGER;
                    sel_d   = next_ch;
                end else begin
                    state_d = IDLE;
                end
            end
            TRIGGER: begin
                if (tick && us_q == TRIG_LAST) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (echo_rise[sel_q]) begin
                    state_d = MEASURE;
                end else if (tick && us_q == RISE_LAST) begin
                    state_d = REPORT;
                    data_d  = RESULT_SAT;
                    tmo_d   = 1'b1;
                end
            end
            MEASURE: begin
                // The tick landing on the fall cycle completes the last microsecond.
                if (tick && us_q == ECHO_LAST) begin
                    state_d = REPORT;
                    data_d  = RESULT_SAT;
                    tmo_d   = 1'b1;
                end else if (echo_fall[sel_q]) begin
                    state_d = REPORT;
                    data_d  = us_q + {15'd0, tick};
                    tmo_d   = 1'b0;
                end
            end
            REPORT: begin
                if (valid_q && res.result_ready) state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (tick && us_q == HOLD_LAST) state_d = SELECT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= LAST_CH;
            presc_q <= '0;
            us_q    <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            if (state_q == SELECT && state_d == TRIGGER) last_q <= next_ch;
            // Timebase restarts on every state change so each phase is measured from entry.
            if (state_d != state_q) begin
                presc_q <= '0;
                us_q    <= '0;
            end else if (state_q inside {TRIGGER, WAIT_RISE, MEASURE, HOLDOFF}) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
                if (tick) us_q <= us_q + 16'd1;
            end
            trig_q  <= (state_d == TRIGGER) ? (ONE_HOT0 << sel_d) : '0;
            valid_q <= (state_d == REPORT);
        end
    end

    assign trigger            = trig_q;
    assign busy               = (state_q != IDLE);
    assign res.result_data    = data_q;
    assign res.result_id      = sel_q;
    assign res.result_timeout = tmo_q;
    assign res.result_valid   = valid_q;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Directed bench for the ultrasonic scan scheduler using short timing parameters.
module tb_ultrasonic_scan_scheduler;

    localparam int CLK_PER_US = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] sensor_mask;
    logic [3:0] echo, echo_resp, echo_man;
    logic [3:0] trigger;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    int resp_width_us = 0;
    int resp_delay    = 4;
    bit resp_busy     = 1'b0;

    ultrasonic_scan_scheduler_if #(.ID_W(2)) res_if ();

    ultrasonic_scan_scheduler #(
        .NUM_SENSORS     (4),
        .CLK_PER_US      (CLK_PER_US),
        .TRIG_US         (2),
        .RISE_TIMEOUT_US (20),
        .MAX_ECHO_US     (50),
        .HOLDOFF_US      (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sensor_mask (sensor_mask),
        .echo        (echo),
        .trigger     (trigger),
        .busy        (busy),
        .res         (res_if)
    );

    assign echo = echo_resp | echo_man;

    always #5 clk = ~clk;

    // Sensor model: after a trigger pulse ends, raise echo on that channel for resp_width_us.
    initial begin : responder
        logic [3:0] trig_prev;
        echo_resp = '0;
        trig_prev = '0;
        forever begin
            @(negedge clk);
            if (trig_prev != 4'b0 && trigger == 4'b0 && resp_width_us > 0 && !reset) begin
                resp_busy = 1'b1;
                repeat (resp_delay) @(negedge clk);
                echo_resp = trig_prev;
                repeat (resp_width_us * CLK_PER_US) @(negedge clk);
                echo_resp = '0;
                resp_busy = 1'b0;
            end
            trig_prev = trigger;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_valid(input int budget, output bit ok);
        int n = 0;
        while (res_if.result_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (res_if.result_valid === 1'b1);
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL wait_valid: result_valid=%b after %0d cycles, required 1", res_if.result_valid, budget);
        end
    endtask

    task automatic wait_trig(input int budget, output bit ok);
        int n = 0;
        while (trigger === 4'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (trigger !== 4'b0);
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL wait_trig: trigger=%b after %0d cycles, required nonzero", trigger, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic accept();
        res_if.result_ready = 1'b1;
        @(negedge clk);
        res_if.result_ready = 1'b0;
    endtask

    task automatic do_reset();
        int n = 0;
        while (resp_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        reset               = 1'b1;
        enable              = 1'b0;
        sensor_mask         = 4'b0;
        echo_man            = 4'b0;
        resp_width_us       = 0;
        res_if.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        compared += 6;
        if (trigger !== 4'b0) begin mismatched++; $display("FAIL rst_trigger: %b vs 0000", trigger); end
        if (res_if.result_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: %b vs 0", res_if.result_valid); end
        if (res_if.result_data !== 16'h0) begin mismatched++; $display("FAIL rst_data: %h vs 0000", res_if.result_data); end
        if (res_if.result_id !== 2'd0) begin mismatched++; $display("FAIL rst_id: %0d vs 0", res_if.result_id); end
        if (res_if.result_timeout !== 1'b0) begin mismatched++; $display("FAIL rst_timeout: %b vs 0", res_if.result_timeout); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: %b vs 0", busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] seen, exp_trig;
        int w;
        do_reset();
        resp_width_us = 30;
        sensor_mask   = 4'b0101;
        enable        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_trig = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            wait_trig(200, ok);
            if (!ok) return;
            seen = trigger;
            w = 0;
            while (trigger != 4'b0 && w < 50) begin
                @(negedge clk);
                w++;
            end
            compared += 2;
            if (seen !== exp_trig) begin mismatched++; $display("FAIL rr_trig_ch[%0d]: %b vs %b", k, seen, exp_trig); end
            if (w !== 4) begin mismatched++; $display("FAIL rr_trig_width[%0d]: %0d vs 4", k, w); end
            wait_valid(300, ok);
            if (!ok) return;
            compared += 3;
            if (res_if.result_id !== ((k % 2 == 0) ? 2'd0 : 2'd2)) begin mismatched++; $display("FAIL rr_id[%0d]: %0d", k, res_if.result_id); end
            if (res_if.result_data !== 16'd30) begin mismatched++; $display("FAIL rr_data[%0d]: %0d vs 30", k, res_if.result_data); end
            if (res_if.result_timeout !== 1'b0) begin mismatched++; $display("FAIL rr_timeout[%0d]: %b vs 0", k, res_if.result_timeout); end
            accept();
        end
        enable = 1'b0;
        wait_idle(100);
    endtask

    task automatic test_rise_timeout();
        bit ok;
        int n;
        do_reset();
        sensor_mask = 4'b0001;
        enable      = 1'b1;
        wait_trig(50, ok);
        if (!ok) return;
        n = 0;
        while (trigger != 4'b0 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (res_if.result_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        compared += 4;
        if (n !== 40) begin mismatched++; $display("FAIL to_latency: %0d cycles vs 40", n); end
        if (res_if.result_data !== 16'hFFFF) begin mismatched++; $display("FAIL to_data: %h vs ffff", res_if.result_data); end
        if (res_if.result_timeout !== 1'b1) begin mismatched++; $display("FAIL to_timeout: %b vs 1", res_if.result_timeout); end
        if (res_if.result_id !== 2'd0) begin mismatched++; $display("FAIL to_id: %0d vs 0", res_if.result_id); end
        accept();
        enable = 1'b0;
        wait_idle(100);
    endtask

    task automatic test_overrange();
        bit ok;
        do_reset();
        resp_width_us = 60;
        sensor_mask   = 4'b0001;
        enable        = 1'b1;
        wait_valid(400, ok);
        if (!ok) return;
        compared += 3;
        if (res_if.result_data !== 16'hFFFF) begin mismatched++; $display("FAIL ovr_data: %h vs ffff", res_if.result_data); end
        if (res_if.result_timeout !== 1'b1) begin mismatched++; $display("FAIL ovr_timeout: %b vs 1", res_if.result_timeout); end
        if (echo_resp[0] !== 1'b1) begin mismatched++; $display("FAIL ovr_early: echo=%b at report, required 1", echo_resp[0]); end
        enable = 1'b0;
        accept();
        wait_idle(100);
    endtask

    task automatic test_width_bounds();
        bit ok;
        int widths[2] = '{1, 49};
        do_reset();
        sensor_mask = 4'b0001;
        enable      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            resp_width_us = widths[k];
            wait_valid(300, ok);
            if (!ok) return;
            compared += 2;
            if (res_if.result_data !== 16'(widths[k])) begin mismatched++; $display("FAIL bound_data[%0d]: %0d vs %0d", k, res_if.result_data, widths[k]); end
            if (res_if.result_timeout !== 1'b0) begin mismatched++; $display("FAIL bound_timeout[%0d]: %b vs 0", k, res_if.result_timeout); end
            if (k == 1) enable = 1'b0;
            accept();
        end
        wait_idle(100);
    endtask

    task automatic test_backpressure();
        bit ok;
        int v_valid = 0, v_data = 0, v_trig = 0;
        do_reset();
        resp_width_us = 10;
        sensor_mask   = 4'b0011;
        enable        = 1'b1;
        wait_valid(300, ok);
        if (!ok) return;
        compared += 2;
        if (res_if.result_data !== 16'd10) begin mismatched++; $display("FAIL bp_data: %0d vs 10", res_if.result_data); end
        if (res_if.result_id !== 2'd0) begin mismatched++; $display("FAIL bp_id: %0d vs 0", res_if.result_id); end
        repeat (100) begin
            @(negedge clk);
            if (res_if.result_valid !== 1'b1) v_valid++;
            if (res_if.result_data !== 16'd10 || res_if.result_id !== 2'd0 || res_if.result_timeout !== 1'b0) v_data++;
            if (trigger !== 4'b0) v_trig++;
        end
        compared += 3;
        if (v_valid !== 0) begin mismatched++; $display("FAIL bp_hold_valid: %0d drops, required 0", v_valid); end
        if (v_data !== 0) begin mismatched++; $display("FAIL bp_hold_data: %0d changes, required 0", v_data); end
        if (v_trig !== 0) begin mismatched++; $display("FAIL bp_no_trigger: %0d cycles with trigger, required 0", v_trig); end
        accept();
        wait_trig(50, ok);
        if (!ok) return;
        compared++;
        if (trigger !== 4'b0010) begin mismatched++; $display("FAIL bp_next_ch: %b vs 0010", trigger); end
        enable = 1'b0;
        wait_valid(300, ok);
        if (!ok) return;
        accept();
        wait_idle(100);
    endtask

    task automatic test_abort_ignored();
        bit ok;
        int n = 0;
        do_reset();
        resp_width_us = 20;
        sensor_mask   = 4'b0001;
        enable        = 1'b1;
        wait_trig(50, ok);
        if (!ok) return;
        while (echo_resp[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        enable      = 1'b0;
        sensor_mask = 4'b0000;
        wait_valid(200, ok);
        if (!ok) return;
        compared += 2;
        if (res_if.result_data !== 16'd20) begin mismatched++; $display("FAIL abort_data: %0d vs 20", res_if.result_data); end
        if (res_if.result_timeout !== 1'b0) begin mismatched++; $display("FAIL abort_timeout: %b vs 0", res_if.result_timeout); end
        accept();
        wait_idle(50);
        compared++;
        if (trigger !== 4'b0) begin mismatched++; $display("FAIL abort_trigger: %b vs 0000", trigger); end
    endtask

    task automatic test_foreign_and_stuck_echo();
        bit ok;
        int n = 0;
        do_reset();
        echo_man = 4'b0001;
        repeat (5) @(negedge clk);
        sensor_mask = 4'b0001;
        enable      = 1'b1;
        wait_trig(50, ok);
        if (!ok) return;
        while (trigger != 4'b0 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        echo_man[1] = 1'b1;
        repeat (8) @(negedge clk);
        echo_man[1] = 1'b0;
        wait_valid(100, ok);
        if (!ok) return;
        compared += 3;
        if (res_if.result_data !== 16'hFFFF) begin mismatched++; $display("FAIL stuck_data: %h vs ffff", res_if.result_data); end
        if (res_if.result_timeout !== 1'b1) begin mismatched++; $display("FAIL stuck_timeout: %b vs 1", res_if.result_timeout); end
        if (res_if.result_id !== 2'd0) begin mismatched++; $display("FAIL stuck_id: %0d vs 0", res_if.result_id); end
        echo_man = 4'b0;
        enable   = 1'b0;
        accept();
        wait_idle(100);
    endtask

    task automatic test_reset_mid_trigger();
        bit ok;
        do_reset();
        resp_width_us = 30;
        sensor_mask   = 4'b0101;
        enable        = 1'b1;
        wait_valid(300, ok);
        if (!ok) return;
        accept();
        wait_trig(50, ok);
        if (!ok) return;
        resp_width_us = 0;
        compared++;
        if (trigger !== 4'b0100) begin mismatched++; $display("FAIL rmid_pre_ch: %b vs 0100", trigger); end
        reset = 1'b1;
        @(negedge clk);
        compared += 3;
        if (trigger !== 4'b0) begin mismatched++; $display("FAIL rmid_trigger: %b vs 0000", trigger); end
        if (res_if.result_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_valid: %b vs 0", res_if.result_valid); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rmid_busy: %b vs 0", busy); end
        reset = 1'b0;
        wait_trig(50, ok);
        if (!ok) return;
        compared++;
        if (trigger !== 4'b0001) begin mismatched++; $display("FAIL rmid_first_ch: %b vs 0001", trigger); end
        enable = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        enable              = 1'b0;
        sensor_mask         = 4'b0;
        echo_man            = 4'b0;
        res_if.result_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_rise_timeout();
        test_overrange();
        test_width_bounds();
        test_backpressure();
        test_abort_ignored();
        test_foreign_and_stuck_echo();
        test_reset_mid_trigger();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
